// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: per-stage stall/flush control for an in-order pipeline,
// including discard of wrong-path fetch responses that return after a redirect.
module pipe_hazard_ctrl #(
   parameter int NUM_STAGES = 6,
   parameter logic [NUM_STAGES-1:0] KILL_SELF = 6'b100000,
   parameter int MAX_OUT = 4,
   parameter int CNT_W = $clog2(MAX_OUT + 1)
) (
   input  logic                  clk,
   input  logic                  resetn,
   input  logic [NUM_STAGES-1:0] stage_wait,
   input  logic [NUM_STAGES-1:0] redirect_req,
   input  logic                  if_req_fire,
   input  logic                  if_resp_valid,
   output logic [NUM_STAGES-1:0] stall,
   output logic [NUM_STAGES-1:0] flush,
   output logic [NUM_STAGES-1:0] redirect_taken,
   output logic                  flush_que,
   output logic                  if_resp_drop,
   output logic [CNT_W-1:0]      disc_cnt,
   output logic [CNT_W-1:0]      out_cnt,
   output logic                  proto_err
);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUT);
   int w, r;
   logic take, kill, drop;
   logic [CNT_W-1:0] out_nxt, disc_nxt;
   // -1 marks "no request"; the highest set index is the oldest requester
   always_comb begin
      w = -1;
      r = -1;
      kill = 1'b0;
      for (int i = 0; i < NUM_STAGES; i++) begin
         if (stage_wait[i]) w = i;
         if (redirect_req[i]) begin
            r = i;
            kill = KILL_SELF[i];
         end
      end
   end
   assign take = r > w;
   assign drop = resetn && !take && if_resp_valid && disc_cnt != '0;
   always_comb begin
      stall = '0;
      flush = '0;
      redirect_taken = '0;
      for (int j = 0; j < NUM_STAGES; j++) begin
         stall[j] = take ? (j == 0 && stage_wait[0]) : j <= w;
         flush[j] = take ? (j >= 1 && j <= r) || (kill && j == r + 1) : w >= 0 && j == w + 1;
         redirect_taken[j] = take && j == r;
      end
      if (drop) begin
         flush[1] = 1'b1;
         stall[0] = 1'b0;
      end
      flush_que = take;
      if_resp_drop = drop;
      if (!resetn) begin
         stall = '0;
         flush = '1;
         redirect_taken = '0;
         flush_que = 1'b1;
      end
   end
   assign out_nxt = (if_req_fire && !if_resp_valid && out_cnt != CNT_MAX) ? out_cnt + 1'b1 :
                    (if_resp_valid && !if_req_fire && out_cnt != '0) ? out_cnt - 1'b1 : out_cnt;
   // a redirect makes everything still in flight, including this cycle's request, stale
   assign disc_nxt = take ? out_nxt : drop ? disc_cnt - 1'b1 : disc_cnt;
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         out_cnt <= '0;
         disc_cnt <= '0;
         proto_err <= 1'b0;
      end else begin
         out_cnt <= out_nxt;
         disc_cnt <= disc_nxt;
         proto_err <= proto_err | (if_req_fire && !if_resp_valid && out_cnt == CNT_MAX) |
                      (if_resp_valid && !if_req_fire && out_cnt == '0);
      end
   end
endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Parametrised stall/flush controller for the N-stage in-order core pipeline.
- Generalises the fixed fetch/decode/execute/memory/writeback hazard unit to a stage vector with per-stage wait and redirect requests, plus a configurable kill-self mask.
- Tracks fetch responses still in flight (up to MAX_OUT) and drops wrong-path responses that return after a redirect.
- Sits beside the pipeline registers. Drives per-stage stall/flush and the fetch-queue flush.

Parameters:
- NUM_STAGES, 6, pipeline stages; index 0 = fetch, NUM_STAGES-1 = writeback (higher index = older).
- KILL_SELF, 6'b100000, bit r=1: a redirect from stage r also kills the requesting instruction (the exception at writeback).
- MAX_OUT, 4, maximum outstanding fetch requests.
- CNT_W, $clog2(MAX_OUT+1), counter width.

Ports:
- clk  in  1  clock.
- resetn  in  1  reset; one clock; reset is asynchronous and active-low.
- stage_wait  in  NUM_STAGES  stage i cannot complete this cycle (cache miss, multi-cycle ALU, decode interlock).
- redirect_req  in  NUM_STAGES  stage i requests a redirect (branch mispredict, misalign, exception); younger stages are wrong-path.
- if_req_fire  in  1  fetch request accepted by the I-side this cycle.
- if_resp_valid  in  1  fetch response returns this cycle.
- stall  out  NUM_STAGES  hold stage i's pipeline register.
- flush  out  NUM_STAGES  the register feeding stage i loads a bubble at the next edge.
- redirect_taken  out  NUM_STAGES  one-hot; the redirect actually honoured.
- flush_que  out  1  clear the fetch-to-decode queue.
- if_resp_drop  out  1  discard the current fetch response.
- disc_cnt  out  CNT_W  stale responses still to discard.
- out_cnt  out  CNT_W  outstanding fetch requests.
- proto_err  out  1  sticky fetch-protocol error.

Behaviour:
- stall, flush, redirect_taken, flush_que and if_resp_drop are combinational from inputs and state.
- Sequential state: out_cnt, disc_cnt, proto_err. All reset asynchronously to 0.
- While resetn=0: stall=0, flush=all ones, redirect_taken=0, flush_que=1, if_resp_drop=0.
- w = highest i with stage_wait[i] (none if zero).
- r = highest i with redirect_req[i].
- Redirect honoured only if r exists and (no w, or r>w). A redirect at r<=w is ignored this cycle; the requester is stalled and re-asserts.
- Honoured redirect:
  - redirect_taken[r]=1, flush_que=1.
  - flush[j]=1 for 1<=j<=r.
  - flush[r+1]=1 too if KILL_SELF[r] and r+1<NUM_STAGES.
  - stall[j]=0 for all j<=r, except stall[0]=1 when stage_wait[0] (fetch keeps its new PC until the I-side accepts it).
  - Stages above r follow the wait rule.
- Wait rule (w exists and not overridden):
  - stall[j]=1 for j<=w.
  - flush[w+1]=1 if w+1<NUM_STAGES (bubble into the next stage).
  - Stages older than w+1 advance.
- No wait, no redirect: all stall=0, flush=0.
- Outstanding fetches: out_cnt_next = out_cnt + if_req_fire - if_resp_valid.
- Discard tracking:
  - On an honoured redirect: disc_cnt_next = out_cnt_next, i.e. every in-flight request, including one fired this cycle, is stale.
  - Otherwise, if if_resp_valid and disc_cnt!=0: if_resp_drop=1, flush[1]=1, stall[0]=0, disc_cnt decrements.
  - A response arriving in the same cycle as a redirect is not counted; the redirect flushes it.
- proto_err sets and stays set until reset on either condition:
  - if_req_fire while out_cnt==MAX_OUT and !if_resp_valid.
  - if_resp_valid while out_cnt==0 and !if_req_fire.
- Counters saturate at 0 and MAX_OUT; they never wrap.
- Reset asserted mid-operation clears all counters immediately. No response is dropped after reset release.

Test Plan:
- Wait only: stage_wait=6'b000100 -> stall=6'b000111, flush=6'b001000; release -> stall=0, flush=0.
- Redirect overrides younger wait: stage_wait=6'b000001, redirect_req=6'b000100 -> redirect_taken=6'b000100, flush=6'b000110, stall=6'b000001, flush_que=1.
- Redirect behind an older wait: stage_wait=6'b010000, redirect_req=6'b000100 -> redirect_taken=0, stall=6'b011111, flush=6'b100000.
- Writeback exception with 2 fetches outstanding plus if_req_fire=1: redirect_req=6'b100000 -> flush=6'b111110, disc_cnt becomes 3. The next 3 if_resp_valid pulses each give if_resp_drop=1 and flush[1]=1; the 4th response passes.
- Redirect in the same cycle as if_resp_valid with out_cnt=1 -> disc_cnt=0 afterwards, flush[1]=1 that cycle, no later drop.
- Protocol error and reset: if_resp_valid with out_cnt=0 -> proto_err=1, sticky. resetn low mid-stream -> out_cnt=disc_cnt=proto_err=0 immediately, flush=all ones.
